envio_serial_tx: RTL and testbench
==================================

// Module: envio_serial_tx
// PURPOSE
//  Asynchronous serial transmitter (UART TX, 7E2 frame) that sits directly downstream of the
//  automatic-send control unit. Accepts one ASCII character per request (envia level),
//  serialises it on saida_serial and returns a one-cycle enviado pulse when the frame is complete.
//  The control unit holds envia high until it sees enviado, then drops it for at least one cycle.
// PARAMETERS
//  BAUD_DIV   434  clock cycles per serial bit (50 MHz / 115200); must be >= 2
//  DATA_BITS  7    data bits per frame, LSB first
// PORTS
//  clock         in   1          system clock, rising edge
//  reset         in   1          asynchronous, active-low reset (0 = reset)
//  envia         in   1          send request level; sampled only in IDLE
//  dado          in   DATA_BITS  character to send; latched at acceptance
//  saida_serial  out  1          serial line, idle high
//  enviado       out  1          one-cycle pulse: frame (incl. both stop bits) finished
//  ocupado       out  1          high from acceptance until DONE inclusive
//  db_estado     out  4          current state code, for debug/7-seg
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, saida_serial=1, enviado=0, ocupado=0, armado=1,
//   shift reg and counters cleared; takes effect immediately, even mid-frame.
//  Frame: start(0), DATA_BITS data LSB first, even parity (XOR of data), 2 stop bits(1) = 11 bits.
//  States (Moore, registered outputs): IDLE=0, START=1, DATA=2, PARIDADE=3, STOP1=4, STOP2=5, DONE=6;
//   unused codes -> IDLE.
//  IDLE: if envia && armado at edge N -> latch dado, go START at N; saida_serial=0 from cycle after N.
//  Each bit state lasts exactly BAUD_DIV cycles (baud counter cleared on every state entry).
//  DATA: shifts one bit per BAUD_DIV; leaves after DATA_BITS bits (bit counter 0..DATA_BITS-1).
//  STOP2 end -> DONE; DONE lasts exactly 1 cycle: enviado=1, saida_serial=1; then IDLE.
//  Latency: acceptance edge -> enviado high = 11*BAUD_DIV + 1 cycles.
//  armado: cleared at acceptance; set again only when envia is sampled 0 in IDLE (or at reset).
//   Hence envia held high after enviado never produces a second frame.
//  envia dropping mid-frame: frame still completes, enviado still pulses.
//  dado changing mid-frame: ignored (latched copy is transmitted).
//  envia rising in the same cycle as DONE: ignored (not IDLE); needs low-then-high in IDLE.
//  ocupado = (state != IDLE). enviado never asserted outside DONE.
// STRUCTURE
//  Shared package/include: state codes, default BAUD_DIV, frame length constant (11).
//  Sub-module: contador_baud (mod-BAUD_DIV counter, inputs zera/conta, output fim on last count).
//  Top: state register + next-state logic, bit counter, shift register, parity bit, armado flag.
// TESTING (bench runs with BAUD_DIV=4)
//  1 reset=0 during cycles 0-3 -> saida_serial=1, enviado=0, ocupado=0, db_estado=0.
//  2 dado=7'h41, envia=1 one cycle -> line 0,1,0,0,0,0,0,1,0,1,1 each 4 cycles; enviado at +45.
//  3 dado=7'h43 ('C', 3 ones) -> parity bit=1; dado switched to 7'h00 mid-frame -> still sends 7'h43.
//  4 envia held high 200 cycles -> exactly one frame and one enviado pulse; armado stays 0.
//  5 UC pattern: envia high until enviado, low 1 cycle, high again, 3 chars -> 3 frames, 3 pulses.
//  6 reset=0 asserted in DATA state -> saida_serial=1 same cycle, IDLE; next request sends full frame.

Source files
------------

// File: rtl/envio_serial_tx_pkg.sv
// Shared definitions for the 7E2 serial transmitter: state codes, default
// baud divisor and frame geometry.
package envio_serial_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_START    = 4'd1,
    ST_DATA     = 4'd2,
    ST_PARIDADE = 4'd3,
    ST_STOP1    = 4'd4,
    ST_STOP2    = 4'd5,
    ST_DONE     = 4'd6
  } estado_t;

  localparam int BAUD_DIV_DEF  = 434;
  localparam int DATA_BITS_DEF = 7;
  localparam int FRAME_BITS    = 11;

endpackage

// File: rtl/envio_serial_tx_contador_baud.sv
// Modulo-BAUD_DIV bit-time counter; fim flags the last cycle of a bit period.
module contador_baud
  import envio_serial_tx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign fim = conta && (cnt_q == CW'(BAUD_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (zera || fim) begin
      cnt_q <= '0;
    end else if (conta) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/envio_serial_tx.sv
// UART transmitter, 7E2 frame: start, DATA_BITS data LSB first, even parity,
// two stop bits. One frame per envia request; enviado pulses when done.
module envio_serial_tx
  import envio_serial_tx_pkg::*;
#(
  parameter int BAUD_DIV  = BAUD_DIV_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 envia,
  input  logic [DATA_BITS-1:0] dado,
  output logic                 saida_serial,
  output logic                 enviado,
  output logic                 ocupado,
  output logic [3:0]           db_estado
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  estado_t              estado_q;
  logic [DATA_BITS-1:0] sr_q;
  logic [BW-1:0]        bit_q;
  logic                 par_q;
  logic                 armado_q;
  logic                 saida_q;
  logic                 enviado_q;
  logic                 zera;
  logic                 fim;

  // Counter is held clear outside the bit-timed states, so every bit state
  // starts from zero and lasts exactly BAUD_DIV cycles.
  assign zera = (estado_q == ST_IDLE) || (estado_q == ST_DONE);

  contador_baud #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (!zera),
    .fim   (fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= ST_IDLE;
      sr_q      <= '0;
      bit_q     <= '0;
      par_q     <= 1'b0;
      armado_q  <= 1'b1;
      saida_q   <= 1'b1;
      enviado_q <= 1'b0;
    end else begin
      // Line level and done pulse are registered from the current state.
      case (estado_q)
        ST_START:    saida_q <= 1'b0;
        ST_DATA:     saida_q <= sr_q[0];
        ST_PARIDADE: saida_q <= par_q;
        default:     saida_q <= 1'b1;
      endcase
      enviado_q <= (estado_q == ST_DONE);

      case (estado_q)
        ST_IDLE: begin
          if (!envia) begin
            armado_q <= 1'b1;
          end else if (armado_q) begin
            sr_q     <= dado;
            par_q    <= ^dado;
            bit_q    <= '0;
            armado_q <= 1'b0;
            estado_q <= ST_START;
          end
        end
        ST_START:    if (fim) estado_q <= ST_DATA;
        ST_DATA: begin
          if (fim) begin
            sr_q <= {1'b0, sr_q[DATA_BITS-1:1]};
            if (bit_q == BW'(DATA_BITS - 1)) estado_q <= ST_PARIDADE;
            else                             bit_q    <= bit_q + 1'b1;
          end
        end
        ST_PARIDADE: if (fim) estado_q <= ST_STOP1;
        ST_STOP1:    if (fim) estado_q <= ST_STOP2;
        ST_STOP2:    if (fim) estado_q <= ST_DONE;
        default:     estado_q <= ST_IDLE;
      endcase
    end
  end

  assign saida_serial = saida_q;
  assign enviado      = enviado_q;
  assign ocupado      = (estado_q != ST_IDLE);
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_envio_serial_tx.sv
// Directed bench for envio_serial_tx with BAUD_DIV=4: frame bit patterns,
// latency, single-shot behaviour, UC handshake and mid-frame reset.
module tb_envio_serial_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       envia;
  logic [6:0] dado;
  logic       saida_serial;
  logic       enviado;
  logic       ocupado;
  logic [3:0] db_estado;

  int n_chk = 0;
  int n_ok  = 0;
  int n_env = 0;

  always #5 clock = ~clock;

  always @(posedge clock) if (enviado === 1'b1) n_env <= n_env + 1;

  envio_serial_tx #(
    .BAUD_DIV  (4),
    .DATA_BITS (7)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .envia        (envia),
    .dado         (dado),
    .saida_serial (saida_serial),
    .enviado      (enviado),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_ok++;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Raises envia, lets the next edge accept, then checks every bit mid-period
  // and the enviado pulse 45 cycles after acceptance. exp[0] is the start bit.
  task automatic do_frame(input logic [6:0] d, input logic [10:0] exp, input string tag,
                          input bit drop, input bit swap);
    dado  = d;
    envia = 1'b1;
    tick;
    chk($sformatf("%s_acc_state", tag), db_estado, 32'd1);
    chk($sformatf("%s_acc_busy", tag), ocupado, 32'd1);
    if (drop) envia = 1'b0;
    for (int b = 0; b < 11; b++) begin
      tick;
      tick;
      chk($sformatf("%s_bit%0d", tag, b), saida_serial, exp[b]);
      tick;
      tick;
      if (swap && b == 3) dado = 7'h00;
    end
    chk($sformatf("%s_done_state", tag), db_estado, 32'd6);
    chk($sformatf("%s_env_early", tag), enviado, 32'd0);
    tick;
    chk($sformatf("%s_env_pulse", tag), enviado, 32'd1);
    chk($sformatf("%s_line_idle", tag), saida_serial, 32'd1);
    chk($sformatf("%s_busy_end", tag), ocupado, 32'd0);
    tick;
    chk($sformatf("%s_env_off", tag), enviado, 32'd0);
    chk($sformatf("%s_idle_after", tag), db_estado, 32'd0);
  endtask

  initial begin
    int e0;
    int bad;
    logic [6:0]  uc_chr [3];
    logic [10:0] uc_exp [3];
    uc_chr[0] = 7'h4F; uc_exp[0] = 11'b11110011110;
    uc_chr[1] = 7'h4B; uc_exp[1] = 11'b11010010110;
    uc_chr[2] = 7'h21; uc_exp[2] = 11'b11001000010;

    // 1: reset state
    reset = 1'b0;
    envia = 1'b0;
    dado  = 7'h00;
    repeat (2) tick;
    chk("rst_line", saida_serial, 32'd1);
    chk("rst_env", enviado, 32'd0);
    chk("rst_busy", ocupado, 32'd0);
    chk("rst_state", db_estado, 32'd0);
    repeat (2) tick;
    reset = 1'b1;
    repeat (2) tick;

    // 2: 'A', single-cycle request
    do_frame(7'h41, 11'b11010000010, "t2A", 1'b1, 1'b0);
    tick;

    // 3: 'C' odd ones, dado changed mid-frame
    do_frame(7'h43, 11'b11110000110, "t3C", 1'b1, 1'b1);
    tick;

    // 4: envia held high for 200 cycles
    e0 = n_env;
    bad = 0;
    do_frame(7'h41, 11'b11010000010, "t4", 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      tick;
      if (db_estado != 4'd0 || saida_serial != 1'b1) bad++;
    end
    chk("t4_no_restart", bad, 32'd0);
    envia = 1'b0;
    tick;
    chk("t4_one_pulse", n_env - e0, 32'd1);

    // 5: UC handshake, three characters back to back
    e0 = n_env;
    for (int i = 0; i < 3; i++) begin
      do_frame(uc_chr[i], uc_exp[i], $sformatf("t5c%0d", i), 1'b0, 1'b0);
      envia = 1'b0;
      tick;
    end
    chk("t5_three_pulses", n_env - e0, 32'd3);

    // 6: asynchronous reset while in DATA
    dado  = 7'h55;
    envia = 1'b1;
    tick;
    envia = 1'b0;
    repeat (10) tick;
    chk("t6_in_data", db_estado, 32'd2);
    chk("t6_line_low", saida_serial, 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_line", saida_serial, 32'd1);
    chk("t6_rst_state", db_estado, 32'd0);
    chk("t6_rst_busy", ocupado, 32'd0);
    repeat (2) tick;
    reset = 1'b1;
    tick;
    do_frame(7'h55, 11'b11010101010, "t6", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
